tbb_tone_gen: RTL

TBB_TONE_GEN -- requirements
Module: tbb_tone_gen

---
 rtl/tbb_pkg.sv | 13 +
 rtl/tbb_tone_chan.sv | 51 +++++
 rtl/tbb_tone_gen.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/tbb_pkg.sv
// Shared constants and helpers for the tone generator: register addresses,
// default startup guard length and the nibble count of a register width.
package tbb_pkg;

  localparam logic [3:0] ADDR_DIV        = 4'hE;
  localparam logic [3:0] ADDR_EN         = 4'hF;
  localparam int         STARTUP_DEFAULT = 5;

  function automatic int nib_count(input int width);
    return (width + 3) / 4;
  endfunction

endpackage

// File: rtl/tbb_tone_chan.sv
// One square-wave channel: holds its active period and produces a toggle
// every P+1 prescaler ticks while enabled with a non-zero period.
module tbb_tone_chan #(
  parameter int PW = 12
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          tick,
  input  logic          en,
  input  logic          per_wr,
  input  logic [PW-1:0] per_wdata,
  output logic          sout
);

  logic [PW-1:0] per_q, per_d;
  logic [PW-1:0] cnt_q, cnt_d;
  logic          sout_q, sout_d;

  // Reloads take per_d so a commit landing on a reload cycle is used at once.
  always_comb begin
    per_d  = per_wr ? per_wdata : per_q;
    cnt_d  = cnt_q;
    sout_d = sout_q;
    if (!en || per_q == '0) begin
      cnt_d  = per_d;
      sout_d = 1'b0;
    end else if (tick) begin
      if (cnt_q == '0) begin
        cnt_d  = per_d;
        sout_d = ~sout_q;
      end else begin
        cnt_d = cnt_q - 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      per_q  <= '0;
      cnt_q  <= '0;
      sout_q <= 1'b0;
    end else begin
      per_q  <= per_d;
      cnt_q  <= cnt_d;
      sout_q <= sout_d;
    end
  end

  assign sout = sout_q;

endmodule

// File: rtl/tbb_tone_gen.sv
// Multi-channel tone generator: synchronised nibble-wide host bus, staged
// register writes with atomic commit, a prescaler with startup guard, NCH channels.
module tbb_tone_gen
  import tbb_pkg::*;
#(
  parameter int NCH     = 3,
  parameter int PW      = 12,
  parameter int STARTUP = STARTUP_DEFAULT
) (
  input  logic           CLK,
  input  logic           RST,
  input  logic           A0,
  input  logic           WR,
  input  logic [3:0]     D,
  output logic [NCH-1:0] SOUT,
  output logic           TICK
);

  localparam int PNIB   = PW / 4;
  localparam int ENIB   = nib_count(NCH);
  localparam int MAXNIB = (PNIB > ENIB) ? PNIB : ENIB;
  localparam int SGW    = 4 * MAXNIB;
  localparam int SW     = (STARTUP < 1) ? 1 : $clog2(STARTUP + 1);

  logic [5:0]     sync1_q, sync1_d, sync2_q, sync2_d;
  logic           wr_prev_q, wr_prev_d;
  logic [3:0]     addr_q, addr_d;
  logic [1:0]     ptr_q, ptr_d, nib_last;
  logic [SGW-1:0] stage_q, stage_d, stage_ins;
  logic [NCH-1:0] en_q, en_d;
  logic [3:0]     div_q, div_d;
  logic [3:0]     pre_q, pre_d;
  logic [SW-1:0]  st_q, st_d;
  logic           tick_q, tick_d;
  logic           wr_det, is_chan, reserved, commit, div_commit;
  logic [NCH-1:0] chan_wr;

  // {WR, A0, D} travel together so the nibble is aligned with its strobe.
  always_comb begin
    sync1_d   = {WR, A0, D};
    sync2_d   = sync1_q;
    wr_prev_d = sync2_q[5];
    wr_det    = sync2_q[5] && !wr_prev_q;
  end

  always_comb begin
    is_chan  = (addr_q < 4'(NCH));
    reserved = !is_chan && (addr_q != ADDR_DIV) && (addr_q != ADDR_EN);
    if (is_chan)                nib_last = 2'(PNIB - 1);
    else if (addr_q == ADDR_EN) nib_last = 2'(ENIB - 1);
    else                        nib_last = 2'd0;

    stage_ins = stage_q;
    for (int i = 0; i < MAXNIB; i++) begin
      if (ptr_q == 2'(i)) stage_ins[4*i +: 4] = sync2_q[3:0];
    end

    addr_d  = addr_q;
    ptr_d   = ptr_q;
    stage_d = stage_q;
    commit  = 1'b0;
    if (wr_det) begin
      if (sync2_q[4]) begin
        addr_d  = sync2_q[3:0];
        ptr_d   = 2'd0;
        stage_d = '0;
      end else if (ptr_q == nib_last) begin
        ptr_d   = 2'd0;
        stage_d = '0;
        commit  = !reserved;
      end else begin
        ptr_d   = ptr_q + 2'd1;
        stage_d = stage_ins;
      end
    end

    div_commit = commit && (addr_q == ADDR_DIV);
    div_d      = div_commit ? stage_ins[3:0] : div_q;
    en_d       = (commit && addr_q == ADDR_EN) ? stage_ins[NCH-1:0] : en_q;
  end

  // The startup guard takes priority; a DIV commit afterwards restarts the count.
  always_comb begin
    st_d   = st_q;
    pre_d  = pre_q;
    tick_d = 1'b0;
    if (st_q < SW'(STARTUP)) begin
      st_d = st_q + 1'b1;
    end else if (div_commit) begin
      pre_d = 4'd0;
    end else if (pre_q == div_q) begin
      pre_d  = 4'd0;
      tick_d = 1'b1;
    end else begin
      pre_d = pre_q + 4'd1;
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      sync1_q   <= '0;
      sync2_q   <= '0;
      wr_prev_q <= 1'b0;
      addr_q    <= '0;
      ptr_q     <= '0;
      stage_q   <= '0;
      en_q      <= '0;
      div_q     <= '0;
      pre_q     <= '0;
      st_q      <= '0;
      tick_q    <= 1'b0;
    end else begin
      sync1_q   <= sync1_d;
      sync2_q   <= sync2_d;
      wr_prev_q <= wr_prev_d;
      addr_q    <= addr_d;
      ptr_q     <= ptr_d;
      stage_q   <= stage_d;
      en_q      <= en_d;
      div_q     <= div_d;
      pre_q     <= pre_d;
      st_q      <= st_d;
      tick_q    <= tick_d;
    end
  end

  assign TICK = tick_q;

  generate
    for (genvar gi = 0; gi < NCH; gi++) begin : g_chan
      assign chan_wr[gi] = commit && (addr_q == 4'(gi));

      tbb_tone_chan #(
        .PW(PW)
      ) u_chan (
        .clk      (CLK),
        .rst_n    (RST),
        .tick     (tick_q),
        .en       (en_q[gi]),
        .per_wr   (chan_wr[gi]),
        .per_wdata(stage_ins[PW-1:0]),
        .sout     (SOUT[gi])
      );
    end
  endgenerate

endmodule
